pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Controls the PC register and the instruction-fetch handshake for the CPU front end.
- Selects the next PC from four sources: sequential +4, branch target, jump target, exception vector.
- Holds the PC across stalls and memory wait states.
- Latches redirects that arrive while the PC cannot advance, and records the exception PC (EPC).
- Sits between the decode/execute control logic and instruction memory.

Parameters:
WIDTH, 32, address width in bits
RESET_ADDR, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h0000_0080, PC value loaded on exception

Ports:
Clk  in  1  clock; rising edge active
Reset  in  1  asynchronous, active-low reset
Stall  in  1  hold PC at the next accept point (hazard stall)
BranchTaken  in  1  branch redirect request
BranchTarget  in  WIDTH  branch target address
Jump  in  1  jump redirect request
JumpTarget  in  WIDTH  jump target address
Exception  in  1  exception request; never stalled
Halt  in  1  enter HALT at the next accept point
Resume  in  1  leave HALT
IfAck  in  1  instruction memory accepted the fetch
IfReq  out  1  fetch request
IfAddr  out  WIDTH  fetch address; always equal to Address
Address  out  WIDTH  current PC
EPC  out  WIDTH  PC captured at the last exception
State  out  2  0=IDLE, 1=FETCH, 2=WAIT, 3=HALT

Behaviour:
Reset and outputs
- Reset low, any time including mid-handshake: immediately Address=RESET_ADDR, EPC=0, State=IDLE, IfReq=0, pending redirect cleared.
- IfReq=1 only in FETCH and WAIT. All outputs are registered except IfReq and IfAddr, which decode State and Address.

State transitions
- IDLE: next cycle -> FETCH. Used after reset and after an exception, so IfReq is low for exactly one cycle.
- FETCH / WAIT, when IfReq & IfAck (an accept):
  - Stall=1: Address held, next state FETCH, so the same address is refetched.
  - Stall=0 (an advance): Address <= next PC; next state HALT if Halt=1, otherwise FETCH.
- FETCH / WAIT, no IfAck: next state WAIT; IfAddr must stay stable.
- HALT: IfReq=0 and Address held. Resume=1 -> FETCH next cycle. Halt is ignored in this state.

Next-PC selection on an advance
- Priority: Jump > BranchTaken > pending redirect > Address+4.
- Live inputs override a latched pending redirect. The pending register clears on every advance.

Pending redirect
- A Jump/BranchTaken seen in FETCH/WAIT on a non-advance cycle is latched as the pending redirect.
- A later jump overwrites a pending branch. A pending jump is overwritten only by a newer jump.
- Redirects seen in HALT or IDLE are ignored.

Exception (highest priority, any state except during reset)
- Next edge: EPC <= Address, Address <= EXC_VECTOR, pending cleared, State <= IDLE.
- An in-flight fetch is abandoned; memory must drop the request when IfReq falls.
- Exception together with an accept: the exception wins and the PC does not advance.

Arithmetic
- Address+4 is modulo 2^WIDTH: 32'hFFFF_FFFC -> 32'h0000_0000.
- Target bits [1:0] are forced to 0 before loading.
- Throughput: one PC advance per cycle when IfAck is tied high and Stall=0.

Test Plan:
1. Reset released, IfAck=1 constant, no redirects -> State 0,1,1,...; Address sequence 0,0,4,8,C. Reset pulsed low mid-run -> Address=0 and IfReq=0 asynchronously.
2. IfAck low for 3 cycles in FETCH at Address=8 -> State WAIT with IfReq=1 and IfAddr=8 throughout. BranchTaken=1 with target 0x40 pulsed during the wait -> on the ack, Address=0x40, not 0xC.
3. Same cycle Jump target 0x100, BranchTaken target 0x200, IfAck=1 -> Address=0x100. JumpTarget 0x103 -> Address=0x100 (bits [1:0] cleared).
4. Stall=1 for 2 accepts at Address=0x20 -> IfAddr=0x20 three times, then 0x24. Address=32'hFFFF_FFFC advances to 0.
5. Exception asserted in WAIT at Address=0x30 -> EPC=0x30, Address=0x80, one IDLE cycle with IfReq=0, then FETCH of 0x80. A branch pending before the exception is discarded.
6. Halt=1 on an accept at 0x10 -> Address=0x14, State=HALT, IfReq=0. Jump pulsed in HALT is ignored. Resume -> FETCH of 0x14. Exception in HALT -> EPC=0x14, Address=0x80.

Source files
------------

// File: rtl/pc_sequencer.sv
// PC register and instruction-fetch handshake controller for the CPU front end.
// Chooses the next PC, holds it across stalls and memory waits, and records EPC.
module pc_sequencer #(
  parameter int unsigned     WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic             Jump,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic             Exception,
  input  logic             Halt,
  input  logic             Resume,
  input  logic             IfAck,
  output logic             IfReq,
  output logic [WIDTH-1:0] IfAddr,
  output logic [WIDTH-1:0] Address,
  output logic [WIDTH-1:0] EPC,
  output logic [1:0]       State
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-3){1'b0}}, 3'd4};

  function automatic logic [WIDTH-1:0] word_align(input logic [WIDTH-1:0] a);
    return {a[WIDTH-1:2], 2'b00};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             pend_valid_q, pend_valid_d;
  logic             pend_jump_q, pend_jump_d;
  logic [WIDTH-1:0] pend_addr_q, pend_addr_d;

  logic             if_req_s;
  logic             accept_s;
  logic             advance_s;
  logic [WIDTH-1:0] next_pc_s;

  assign if_req_s  = (state_q == S_FETCH) || (state_q == S_WAIT);
  assign accept_s  = if_req_s & IfAck;
  assign advance_s = accept_s & ~Stall;

  assign IfReq   = if_req_s;
  assign IfAddr  = addr_q;
  assign Address = addr_q;
  assign EPC     = epc_q;
  assign State   = state_q;

  // Live redirects beat a latched one; sequential fetch is the fallback.
  always_comb begin
    next_pc_s = addr_q + PC_STEP;
    if (Jump) begin
      next_pc_s = word_align(JumpTarget);
    end else if (BranchTaken) begin
      next_pc_s = word_align(BranchTarget);
    end else if (pend_valid_q) begin
      next_pc_s = pend_addr_q;
    end else begin
      next_pc_s = addr_q + PC_STEP;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    epc_d        = epc_q;
    pend_valid_d = pend_valid_q;
    pend_jump_d  = pend_jump_q;
    pend_addr_d  = pend_addr_q;

    if (Exception) begin
      epc_d        = addr_q;
      addr_d       = EXC_VECTOR;
      pend_valid_d = 1'b0;
      pend_jump_d  = 1'b0;
      state_d      = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_FETCH;
        end
        S_FETCH, S_WAIT: begin
          if (advance_s) begin
            addr_d       = next_pc_s;
            pend_valid_d = 1'b0;
            pend_jump_d  = 1'b0;
            state_d      = Halt ? S_HALT : S_FETCH;
          end else begin
            state_d = accept_s ? S_FETCH : S_WAIT;
            // A latched jump may only be displaced by a newer jump.
            if (Jump) begin
              pend_valid_d = 1'b1;
              pend_jump_d  = 1'b1;
              pend_addr_d  = word_align(JumpTarget);
            end else if (BranchTaken && !(pend_valid_q && pend_jump_q)) begin
              pend_valid_d = 1'b1;
              pend_jump_d  = 1'b0;
              pend_addr_d  = word_align(BranchTarget);
            end else begin
              pend_valid_d = pend_valid_q;
            end
          end
        end
        S_HALT: begin
          state_d = Resume ? S_FETCH : S_HALT;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      addr_q       <= RESET_ADDR;
      epc_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_jump_q  <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      epc_q        <= epc_d;
      pend_valid_q <= pend_valid_d;
      pend_jump_q  <= pend_jump_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; each task covers one scenario.
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Stall = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = 32'h0;
  logic        Jump = 1'b0;
  logic [31:0] JumpTarget = 32'h0;
  logic        Exception = 1'b0;
  logic        Halt = 1'b0;
  logic        Resume = 1'b0;
  logic        IfAck = 1'b0;
  logic        IfReq;
  logic [31:0] IfAddr;
  logic [31:0] Address;
  logic [31:0] EPC;
  logic [1:0]  State;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget), .Exception(Exception),
    .Halt(Halt), .Resume(Resume), .IfAck(IfAck),
    .IfReq(IfReq), .IfAddr(IfAddr), .Address(Address), .EPC(EPC), .State(State)
  );

  always #5 Clk = ~Clk;

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  // Leaves the DUT in IDLE at RESET_ADDR, mid-cycle, with all requests low.
  task automatic do_reset;
    @(posedge Clk);
    #1;
    Reset = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; Jump = 1'b0;
    Exception = 1'b0; Halt = 1'b0; Resume = 1'b0; IfAck = 1'b1;
    #2;
    Reset = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (State !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", State); end
    checks++; if (Address !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", Address); end
    checks++; if (IfReq !== 1'b0) begin errors++; $display("FAIL rst_ifreq got %b exp 0", IfReq); end
    checks++; if (EPC !== 32'h0) begin errors++; $display("FAIL rst_epc got %h exp 0", EPC); end
    step();
    checks++; if (State !== 2'd1 || Address !== 32'h0 || IfReq !== 1'b1)
      begin errors++; $display("FAIL seq0 state %0d addr %h req %b exp 1/0/1", State, Address, IfReq); end
    step();
    checks++; if (State !== 2'd1 || Address !== 32'h4) begin errors++; $display("FAIL seq4 got %h exp 4", Address); end
    step();
    checks++; if (Address !== 32'h8) begin errors++; $display("FAIL seq8 got %h exp 8", Address); end
    step();
    checks++; if (Address !== 32'hC) begin errors++; $display("FAIL seqC got %h exp C", Address); end
    Reset = 1'b0;
    #1;
    checks++; if (Address !== 32'h0 || IfReq !== 1'b0 || State !== 2'd0)
      begin errors++; $display("FAIL async_rst addr %h req %b state %0d exp 0/0/0", Address, IfReq, State); end
    Reset = 1'b1;
  endtask

  task automatic test_wait_branch;
    do_reset();
    step(); step(); step();
    checks++; if (Address !== 32'h8) begin errors++; $display("FAIL wb_start got %h exp 8", Address); end
    IfAck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      BranchTaken = (i == 0); BranchTarget = 32'h40;
      step();
      checks++; if (State !== 2'd2 || IfReq !== 1'b1 || IfAddr !== 32'h8)
        begin errors++; $display("FAIL wb_wait%0d state %0d req %b ifaddr %h exp 2/1/8", i, State, IfReq, IfAddr); end
    end
    BranchTaken = 1'b0;
    IfAck = 1'b1;
    step();
    checks++; if (Address !== 32'h40 || State !== 2'd1)
      begin errors++; $display("FAIL wb_redirect addr %h state %0d exp 40/1", Address, State); end
    step();
    checks++; if (Address !== 32'h44) begin errors++; $display("FAIL wb_after got %h exp 44", Address); end
  endtask

  task automatic test_jump_branch;
    do_reset();
    step();
    Jump = 1'b1; JumpTarget = 32'h100; BranchTaken = 1'b1; BranchTarget = 32'h200;
    step();
    checks++; if (Address !== 32'h100) begin errors++; $display("FAIL jb_prio got %h exp 100", Address); end
    BranchTaken = 1'b0; JumpTarget = 32'h103;
    step();
    checks++; if (Address !== 32'h100) begin errors++; $display("FAIL jb_align got %h exp 100", Address); end
    Jump = 1'b0;
    step();
    checks++; if (Address !== 32'h104) begin errors++; $display("FAIL jb_seq got %h exp 104", Address); end
  endtask

  task automatic test_stall;
    do_reset();
    step();
    Jump = 1'b1; JumpTarget = 32'h20;
    step();
    Jump = 1'b0;
    checks++; if (IfAddr !== 32'h20) begin errors++; $display("FAIL st_a got %h exp 20", IfAddr); end
    Stall = 1'b1;
    step();
    checks++; if (IfAddr !== 32'h20 || State !== 2'd1) begin errors++; $display("FAIL st_b got %h/%0d exp 20/1", IfAddr, State); end
    step();
    checks++; if (IfAddr !== 32'h20) begin errors++; $display("FAIL st_c got %h exp 20", IfAddr); end
    Stall = 1'b0;
    step();
    checks++; if (IfAddr !== 32'h24) begin errors++; $display("FAIL st_d got %h exp 24", IfAddr); end
    Jump = 1'b1; JumpTarget = 32'hFFFF_FFFC;
    step();
    Jump = 1'b0;
    checks++; if (Address !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_a got %h exp FFFFFFFC", Address); end
    step();
    checks++; if (Address !== 32'h0) begin errors++; $display("FAIL wrap_b got %h exp 0", Address); end
  endtask

  task automatic test_exception;
    do_reset();
    step();
    Jump = 1'b1; JumpTarget = 32'h30;
    step();
    Jump = 1'b0; IfAck = 1'b0;
    step();
    checks++; if (State !== 2'd2 || Address !== 32'h30) begin errors++; $display("FAIL ex_wait %0d/%h exp 2/30", State, Address); end
    BranchTaken = 1'b1; BranchTarget = 32'h40;
    step();
    BranchTaken = 1'b0; Exception = 1'b1;
    step();
    Exception = 1'b0; IfAck = 1'b1;
    checks++; if (EPC !== 32'h30 || Address !== 32'h80)
      begin errors++; $display("FAIL ex_take epc %h addr %h exp 30/80", EPC, Address); end
    checks++; if (State !== 2'd0 || IfReq !== 1'b0) begin errors++; $display("FAIL ex_idle %0d/%b exp 0/0", State, IfReq); end
    step();
    checks++; if (State !== 2'd1 || IfReq !== 1'b1 || IfAddr !== 32'h80)
      begin errors++; $display("FAIL ex_fetch %0d/%b/%h exp 1/1/80", State, IfReq, IfAddr); end
    step();
    checks++; if (Address !== 32'h84) begin errors++; $display("FAIL ex_pend_drop got %h exp 84", Address); end
    Exception = 1'b1;
    step();
    Exception = 1'b0;
    checks++; if (EPC !== 32'h84 || Address !== 32'h80 || State !== 2'd0)
      begin errors++; $display("FAIL ex_vs_accept %h/%h/%0d exp 84/80/0", EPC, Address, State); end
  endtask

  task automatic test_halt;
    do_reset();
    step();
    Jump = 1'b1; JumpTarget = 32'h10;
    step();
    Jump = 1'b0; Halt = 1'b1;
    step();
    Halt = 1'b0;
    checks++; if (Address !== 32'h14 || State !== 2'd3 || IfReq !== 1'b0)
      begin errors++; $display("FAIL h_enter %h/%0d/%b exp 14/3/0", Address, State, IfReq); end
    Jump = 1'b1; JumpTarget = 32'h200;
    step();
    Jump = 1'b0;
    checks++; if (Address !== 32'h14 || State !== 2'd3) begin errors++; $display("FAIL h_hold %h/%0d exp 14/3", Address, State); end
    Resume = 1'b1;
    step();
    Resume = 1'b0;
    checks++; if (State !== 2'd1 || IfReq !== 1'b1 || IfAddr !== 32'h14)
      begin errors++; $display("FAIL h_resume %0d/%b/%h exp 1/1/14", State, IfReq, IfAddr); end
    step();
    checks++; if (Address !== 32'h18) begin errors++; $display("FAIL h_nojump got %h exp 18", Address); end
    Jump = 1'b1; JumpTarget = 32'h10;
    step();
    Jump = 1'b0; Halt = 1'b1;
    step();
    Halt = 1'b0; Exception = 1'b1;
    step();
    Exception = 1'b0;
    checks++; if (EPC !== 32'h14 || Address !== 32'h80 || State !== 2'd0)
      begin errors++; $display("FAIL h_exc %h/%h/%0d exp 14/80/0", EPC, Address, State); end
  endtask

  initial begin
    test_reset();
    test_wait_branch();
    test_jump_branch();
    test_stall();
    test_exception();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
